spi_eeprom_responder: RTL and testbench

Synthesizable SPI target (mode 0) that answers a 25AA-style EEPROM command subset from a small on-chip byte memory. It is the far end of the SPI link driven by the AXI-Lite-to-SPI master. It gives the system bench and FPGA loop-back builds a clock-synchronous EEPROM substitute with no behavioural model and no write-cycle delay. SCK, MOSI and CSn are oversampled on ACLK.

---
 rtl/spi_eeprom_pkg.sv | 35 +++
 rtl/spi_eeprom_responder_if.sv | 10 +
 rtl/spi_sync_edge.sv | 53 +++++
 rtl/spi_eeprom_responder.sv | 156 +++++++++++++++
 tb/tb_spi_eeprom_responder.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/spi_eeprom_pkg.sv
// Shared constants for the SPI EEPROM responder: opcodes, status bit layout
// and the command FSM encoding.
package spi_eeprom_pkg;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam int STATUS_WEL_BIT = 1;
    localparam int STATUS_WIP_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_WDATA,
        ST_RDATA,
        ST_RDSR,
        ST_DONE,
        ST_IGNORE
    } state_t;

    // Writes complete instantly, so WIP always reads back as 0.
    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] s;
        s = '0;
        s[STATUS_WEL_BIT] = wel;
        s[STATUS_WIP_BIT] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/spi_eeprom_responder_if.sv
// Four-wire SPI link between a master and the EEPROM responder.
interface spi_eeprom_responder_if;
    logic SPI_SCK;
    logic SPI_CSn;
    logic SPI_MOSI;
    logic SPI_MISO;

    modport master (output SPI_SCK, output SPI_CSn, output SPI_MOSI, input SPI_MISO);
    modport slave  (input SPI_SCK, input SPI_CSn, input SPI_MOSI, output SPI_MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Synchronizes SCK/MOSI/CSn into the system clock and flags SCK and CSn edges.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);

    logic [2:0] pins;
    logic [2:0] synced;
    logic [1:0] prev_reg;

    assign pins = {cs_n, mosi, sck};

    // CSn resets to the "low" level so a frame already open at reset release
    // produces no fall edge and stays ignored until CSn rises again.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
                end
            end
            assign synced[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_reg <= '0;
        end else begin
            prev_reg <= {synced[2], synced[0]};
        end
    end

    assign sck_rise = synced[0] & ~prev_reg[0];
    assign sck_fall = ~synced[0] & prev_reg[0];
    assign cs_rise  = synced[2] & ~prev_reg[1];
    assign cs_fall  = ~synced[2] & prev_reg[1];
    assign mosi_s   = synced[1];

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 target emulating a 25AA-style EEPROM subset backed by on-chip RAM.
module spi_eeprom_responder
    import spi_eeprom_pkg::*;
#(
    parameter int MEM_AW      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    spi_eeprom_responder_if.slave   spi
);

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

    state_t              state_reg, state_next;
    logic [2:0]          bit_cnt_reg;
    logic [6:0]          shift_reg;
    logic [7:0]          addr_h_reg;
    logic [15:0]         addr_reg;
    logic                wel_reg;
    logic                op_write_reg;
    logic                miso_reg;
    logic [6:0]          tx_reg;
    logic [7:0]          rd_data_reg;
    logic [7:0]          mem [2**MEM_AW];

    logic [7:0]          rx_byte;
    logic                byte_done;
    logic [15:0]         addr_load;
    logic [15:0]         addr_inc;
    logic                mem_we;
    logic                rd_en;
    logic [MEM_AW-1:0]   rd_addr;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .sck      (spi.SPI_SCK),
        .cs_n     (spi.SPI_CSn),
        .mosi     (spi.SPI_MOSI),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .mosi_s   (mosi_s)
    );

    assign rx_byte   = {shift_reg, mosi_s};
    assign byte_done = sck_rise && !cs_rise && (bit_cnt_reg == 3'd7);
    assign addr_load = {addr_h_reg, rx_byte};
    assign addr_inc  = addr_reg + 16'd1;

    always_comb begin
        state_next = state_reg;
        mem_we     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = addr_inc[MEM_AW-1:0];
        if (cs_rise) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   if (cs_fall) state_next = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            OP_WREN, OP_WRDI:  state_next = ST_DONE;
                            OP_RDSR:           state_next = ST_RDSR;
                            OP_READ, OP_WRITE: state_next = ST_ADDR_H;
                            default:           state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR_H: if (byte_done) state_next = ST_ADDR_L;
                ST_ADDR_L: begin
                    // First read byte is fetched while the last address bit lands.
                    rd_addr = addr_load[MEM_AW-1:0];
                    if (byte_done) begin
                        state_next = op_write_reg ? ST_WDATA : ST_RDATA;
                        rd_en      = !op_write_reg;
                    end
                end
                ST_WDATA:  mem_we = byte_done && wel_reg;
                ST_RDATA:  rd_en  = byte_done;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            mem[addr_reg[MEM_AW-1:0]] <= rx_byte;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            addr_h_reg   <= '0;
            addr_reg     <= '0;
            wel_reg      <= 1'b0;
            op_write_reg <= 1'b0;
            miso_reg     <= 1'b0;
            tx_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (cs_rise || cs_fall) begin
                bit_cnt_reg  <= '0;
                shift_reg    <= '0;
                tx_reg       <= '0;
                miso_reg     <= 1'b0;
                op_write_reg <= 1'b0;
                if (cs_rise && op_write_reg) begin
                    wel_reg <= 1'b0;
                end
            end else if (state_reg != ST_IDLE) begin
                if (sck_rise) begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    shift_reg   <= rx_byte[6:0];
                end
                if (byte_done) begin
                    case (state_reg)
                        ST_CMD: begin
                            op_write_reg <= (rx_byte == OP_WRITE);
                            if (rx_byte == OP_WREN) wel_reg <= 1'b1;
                            if (rx_byte == OP_WRDI) wel_reg <= 1'b0;
                        end
                        ST_ADDR_H:          addr_h_reg <= rx_byte;
                        ST_ADDR_L:          addr_reg   <= addr_load;
                        ST_WDATA, ST_RDATA: addr_reg   <= addr_inc;
                        default:            ;
                    endcase
                end
                // A new outgoing byte is loaded on the first fall of each byte slot.
                if (sck_fall) begin
                    if (state_reg == ST_RDATA && bit_cnt_reg == 3'd0) begin
                        {miso_reg, tx_reg} <= rd_data_reg;
                    end else if (state_reg == ST_RDSR && bit_cnt_reg == 3'd0) begin
                        {miso_reg, tx_reg} <= status_byte(wel_reg);
                    end else if (state_reg == ST_RDATA || state_reg == ST_RDSR) begin
                        {miso_reg, tx_reg} <= {tx_reg, 1'b0};
                    end else begin
                        {miso_reg, tx_reg} <= '0;
                    end
                end
            end
        end
    end

    assign spi.SPI_MISO = miso_reg;

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed frame-level bench for spi_eeprom_responder driven at SCK = ACLK/16.
module tb_spi_eeprom_responder;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    spi_eeprom_responder_if spi_if ();

    spi_eeprom_responder #(.MEM_AW(8), .SYNC_STAGES(2)) dut (
        .ACLK    (clk),
        .ARESETn (rstn),
        .spi     (spi_if)
    );

    typedef struct {
        string       name;
        int          n;
        logic [47:0] tx;
        logic [47:0] exp;
        logic [5:0]  chk;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(input string name, input int n, input logic [47:0] tx,
                                input logic [47:0] exp, input logic [5:0] chk);
        vec_t v;
        v.name = name;
        v.n    = n;
        v.tx   = tx;
        v.exp  = exp;
        v.chk  = chk;
        vecs.push_back(v);
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Mode 0: MOSI set in the low phase, MISO sampled just before the rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_if.SPI_MOSI = tx[7-i];
            repeat (8) @(negedge clk);
            rx = {rx[6:0], spi_if.SPI_MISO};
            spi_if.SPI_SCK = 1'b1;
            repeat (8) @(negedge clk);
            spi_if.SPI_SCK = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_if.SPI_CSn = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (8) @(negedge clk);
        spi_if.SPI_CSn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input int n, input logic [47:0] tx,
                             input logic [47:0] exp, input logic [5:0] chk);
        logic [7:0] rx;
        cs_low();
        for (int i = 0; i < n; i++) begin
            spi_bits(tx[47-8*i -: 8], 8, rx);
            if (chk[5-i]) check8($sformatf("%s.b%0d", name, i), rx, exp[47-8*i -: 8]);
        end
        cs_high();
        $display("[TB] frame %-14s tx=%012h bytes=%0d", name, tx, n);
    endtask

    initial begin
        logic [7:0] rx;

        spi_if.SPI_SCK  = 1'b0;
        spi_if.SPI_CSn  = 1'b1;
        spi_if.SPI_MOSI = 1'b0;
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        check8("reset_miso", {7'b0, spi_if.SPI_MISO}, 8'h00);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        add("rdsr_rst",   2, 48'h05_00_00_00_00_00, 48'h00_00_00_00_00_00, 6'b110000);
        add("pre_wren1",  1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        add("pre_w10",    4, 48'h02_00_10_00_00_00, 48'h0, 6'b000000);
        add("pre_wren2",  1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        add("pre_w20",    5, 48'h02_00_20_00_5A_00, 48'h0, 6'b000000);
        add("pre_wren3",  1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        add("pre_w30",    4, 48'h02_00_30_3C_00_00, 48'h0, 6'b000000);
        add("wren_a",     1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        add("write_f0",   4, 48'h02_00_F0_AA_00_00, 48'h0, 6'b000000);
        add("read_f0",    4, 48'h03_00_F0_00_00_00, 48'h00_00_00_AA_00_00, 6'b111100);
        add("read_1f0",   4, 48'h03_01_F0_00_00_00, 48'h00_00_00_AA_00_00, 6'b000100);
        add("write_10nw", 4, 48'h02_00_10_55_00_00, 48'h0, 6'b000000);
        add("read_10",    4, 48'h03_00_10_00_00_00, 48'h00_00_00_00_00_00, 6'b000100);
        add("rdsr_a",     2, 48'h05_00_00_00_00_00, 48'h00_00_00_00_00_00, 6'b010000);
        add("wren_b",     1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        add("rdsr_2",     3, 48'h05_00_00_00_00_00, 48'h00_02_02_00_00_00, 6'b111000);
        add("write_40",   4, 48'h02_00_40_99_00_00, 48'h0, 6'b000000);
        add("rdsr_b",     2, 48'h05_00_00_00_00_00, 48'h00_00_00_00_00_00, 6'b010000);
        add("wren_c",     1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        add("wrdi",       1, 48'h04_00_00_00_00_00, 48'h0, 6'b000000);
        add("rdsr_c",     2, 48'h05_00_00_00_00_00, 48'h00_00_00_00_00_00, 6'b010000);
        add("read_40",    4, 48'h03_00_40_00_00_00, 48'h00_00_00_99_00_00, 6'b000100);
        add("wren_d",     1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        add("write_ff",   5, 48'h02_00_FF_11_22_00, 48'h0, 6'b000000);
        add("read_ff",    5, 48'h03_00_FF_00_00_00, 48'h00_00_00_11_22_00, 6'b000110);
        add("read_00",    4, 48'h03_00_00_00_00_00, 48'h00_00_00_22_00_00, 6'b000100);
        add("op_9f",      4, 48'h9F_FF_FF_FF_00_00, 48'h00_00_00_00_00_00, 6'b111100);

        for (int k = 0; k < vecs.size(); k++) begin
            run_frame(vecs[k].name, vecs[k].n, vecs[k].tx, vecs[k].exp, vecs[k].chk);
        end

        // Trailing partial byte after a complete data byte must be dropped.
        run_frame("wren_e", 1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        cs_low();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h20, 8, rx);
        spi_bits(8'h77, 8, rx);
        spi_bits(8'hF0, 4, rx);
        cs_high();
        $display("[TB] frame %-14s write 0x20=0x77 plus 4 bits", "partial");
        run_frame("read_20",  5, 48'h03_00_20_00_00_00, 48'h00_00_00_77_5A_00, 6'b000110);
        run_frame("rdsr_part", 2, 48'h05_00_00_00_00_00, 48'h00_00_00_00_00_00, 6'b010000);

        // Reset in the middle of a write data byte; the open frame stays dead.
        run_frame("wren_f", 1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        cs_low();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h30, 8, rx);
        spi_bits(8'hC3, 4, rx);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check8("rst_mid_miso", {7'b0, spi_if.SPI_MISO}, 8'h00);
        rstn = 1'b1;
        spi_bits(8'h30, 4, rx);
        spi_bits(8'hE7, 8, rx);
        cs_high();
        $display("[TB] frame %-14s reset during data byte at 0x30", "rst_abort");
        run_frame("rdsr_rst2", 2, 48'h05_00_00_00_00_00, 48'h00_00_00_00_00_00, 6'b010000);
        run_frame("read_30",   4, 48'h03_00_30_00_00_00, 48'h00_00_00_3C_00_00, 6'b000100);
        run_frame("wren_g",    1, 48'h06_00_00_00_00_00, 48'h0, 6'b000000);
        run_frame("write_31",  4, 48'h02_00_31_66_00_00, 48'h0, 6'b000000);
        run_frame("read_30b",  5, 48'h03_00_30_00_00_00, 48'h00_00_00_3C_66_00, 6'b000110);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
